// File: rtl/vga_pkg.sv
// Shared timing defaults, counter width and FSM state type for the VGA timing generator.
package vga_pkg;
  localparam int CNT_W = 12;
  localparam int RGB_W = 24;

  localparam int DEF_H_ACTIVE = 1600;
  localparam int DEF_H_FP     = 64;
  localparam int DEF_H_SYNC   = 192;
  localparam int DEF_H_BP     = 304;
  localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;

  localparam int DEF_V_ACTIVE = 1200;
  localparam int DEF_V_FP     = 1;
  localparam int DEF_V_SYNC   = 3;
  localparam int DEF_V_BP     = 46;
  localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic {
    WAIT_LOCK = 1'b0,
    RUN       = 1'b1
  } state_t;

  // Half-open window test used for both sync pulses.
  function automatic logic in_window(input cnt_t pos, input cnt_t lo, input cnt_t hi);
    return (pos >= lo) && (pos < hi);
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for slow level signals crossing into the clk domain.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: issues pixel requests, then re-aligns syncs/de with the returned pixel data.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic HS_POL   = 1'b1,
  parameter logic VS_POL   = 1'b1,
  parameter int   RD_LAT   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pll_locked,
  output logic             req_valid,
  output logic [CNT_W-1:0] req_x,
  output logic [CNT_W-1:0] req_y,
  input  logic [RGB_W-1:0] rgb_in,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic [RGB_W-1:0] rgb_out,
  output logic             frame_start
);
  localparam int   H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int   V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam cnt_t H_ACT_C   = cnt_t'(H_ACTIVE);
  localparam cnt_t H_SYNC_LO = cnt_t'(H_ACTIVE + H_FP);
  localparam cnt_t H_SYNC_HI = cnt_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam cnt_t H_LAST    = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_ACT_C   = cnt_t'(V_ACTIVE);
  localparam cnt_t V_SYNC_LO = cnt_t'(V_ACTIVE + V_FP);
  localparam cnt_t V_SYNC_HI = cnt_t'(V_ACTIVE + V_FP + V_SYNC);
  localparam cnt_t V_LAST    = cnt_t'(V_TOTAL - 1);
  localparam int   PIPE_D    = RD_LAT + 1;

  state_t state, state_nxt;
  cnt_t   h, v, h_nxt, v_nxt;
  logic   lock_s;
  logic   run_nxt, active_nxt, hs_act_nxt, vs_act_nxt;
  logic   hs_act, vs_act;
  logic [PIPE_D-1:0] de_pipe, hs_pipe, vs_pipe;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (lock_s)
  );

  // The request-side outputs are registered from the *next* position so they line up
  // with the counters; entering RUN therefore lands directly on pixel (0,0).
  always_comb begin
    state_nxt = state;
    h_nxt     = '0;
    v_nxt     = '0;
    if (state == WAIT_LOCK) begin
      if (lock_s) state_nxt = RUN;
    end else if (!lock_s) begin
      state_nxt = WAIT_LOCK;
    end else begin
      h_nxt = (h == H_LAST) ? '0 : h + cnt_t'(1);
      v_nxt = v;
      if (h == H_LAST) v_nxt = (v == V_LAST) ? '0 : v + cnt_t'(1);
    end
  end

  assign run_nxt    = (state_nxt == RUN);
  assign active_nxt = run_nxt && (h_nxt < H_ACT_C) && (v_nxt < V_ACT_C);
  assign hs_act_nxt = run_nxt && in_window(h_nxt, H_SYNC_LO, H_SYNC_HI);
  assign vs_act_nxt = run_nxt && in_window(v_nxt, V_SYNC_LO, V_SYNC_HI);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= WAIT_LOCK;
      h           <= '0;
      v           <= '0;
      req_valid   <= 1'b0;
      req_x       <= '0;
      req_y       <= '0;
      frame_start <= 1'b0;
      hs_act      <= 1'b0;
      vs_act      <= 1'b0;
    end else begin
      state       <= state_nxt;
      h           <= h_nxt;
      v           <= v_nxt;
      req_valid   <= active_nxt;
      req_x       <= active_nxt ? h_nxt : '0;
      req_y       <= active_nxt ? v_nxt : '0;
      frame_start <= run_nxt && (h_nxt == '0) && (v_nxt == '0);
      hs_act      <= hs_act_nxt;
      vs_act      <= vs_act_nxt;
    end
  end

  // Sync levels are stored already polarised so the output pins come straight off flops.
  // Losing lock flushes everything in flight so no stale pixels reach the display.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_pipe <= '0;
      hs_pipe <= {PIPE_D{~HS_POL}};
      vs_pipe <= {PIPE_D{~VS_POL}};
      rgb_out <= '0;
    end else if (!run_nxt) begin
      de_pipe <= '0;
      hs_pipe <= {PIPE_D{~HS_POL}};
      vs_pipe <= {PIPE_D{~VS_POL}};
      rgb_out <= '0;
    end else begin
      de_pipe <= {de_pipe[PIPE_D-2:0], req_valid};
      hs_pipe <= {hs_pipe[PIPE_D-2:0], (hs_act ? HS_POL : ~HS_POL)};
      vs_pipe <= {vs_pipe[PIPE_D-2:0], (vs_act ? VS_POL : ~VS_POL)};
      rgb_out <= de_pipe[PIPE_D-2] ? rgb_in : '0;
    end
  end

  assign de    = de_pipe[PIPE_D-1];
  assign hsync = hs_pipe[PIPE_D-1];
  assign vsync = vs_pipe[PIPE_D-1];
endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench on a 14x7 raster: a position-arithmetic model predicts every output each cycle.
module tb_vga_timing_gen;
  localparam int   HA = 8, HFP = 2, HSW = 2, HBP = 2;
  localparam int   VA = 4, VFP = 1, VSW = 1, VBP = 1;
  localparam int   HT = HA + HFP + HSW + HBP;
  localparam int   VT = VA + VFP + VSW + VBP;
  localparam int   FRAME = HT * VT;
  localparam int   LAT = 3;
  localparam logic HP = 1'b1;
  localparam logic VP = 1'b0;

  typedef struct packed {
    logic        valid;
    logic [11:0] x;
    logic [11:0] y;
    logic        fs;
    logic        hs;
    logic        vs;
  } pix_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pll_locked;
  logic        req_valid;
  logic [11:0] req_x, req_y;
  logic [23:0] rgb_in;
  logic        hsync, vsync, de;
  logic [23:0] rgb_out;
  logic        frame_start;

  int          checks = 0;
  int          passes = 0;
  logic [23:0] data_key;

  logic m_s1, m_s2, m_run;
  int   m_t;
  pix_t hist [0:LAT+1];

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(HP), .VS_POL(VP), .RD_LAT(LAT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pll_locked  (pll_locked),
    .req_valid   (req_valid),
    .req_x       (req_x),
    .req_y       (req_y),
    .rgb_in      (rgb_in),
    .hsync       (hsync),
    .vsync       (vsync),
    .de          (de),
    .rgb_out     (rgb_out),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  function automatic pix_t pixel_at(input int t);
    int   h, v;
    pix_t p;
    h = t % HT;
    v = t / HT;
    p.valid = (h < HA) && (v < VA);
    p.x  = p.valid ? 12'(h) : 12'd0;
    p.y  = p.valid ? 12'(v) : 12'd0;
    p.fs = (t == 0);
    p.hs = (h >= HA + HFP && h < HA + HFP + HSW) ? HP : ~HP;
    p.vs = (v >= VA + VFP && v < VA + VFP + VSW) ? VP : ~VP;
    return p;
  endfunction

  function automatic pix_t idle_pix();
    pix_t p;
    p    = '0;
    p.hs = ~HP;
    p.vs = ~VP;
    return p;
  endfunction

  function automatic logic [23:0] pix_data(input logic [11:0] x, input logic [11:0] y);
    return {y, x} ^ data_key;
  endfunction

  task automatic model_reset();
    m_s1  = 1'b0;
    m_s2  = 1'b0;
    m_run = 1'b0;
    m_t   = 0;
    for (int i = 0; i <= LAT + 1; i++) hist[i] = idle_pix();
  endtask

  // Raster position is a single running pixel index; hist[k] is what the request side showed k clocks ago.
  task automatic model_tick();
    if (m_run && m_s2) m_t = (m_t + 1) % FRAME;
    else m_t = 0;
    m_run = m_s2;
    m_s2  = m_s1;
    m_s1  = pll_locked;
    for (int i = LAT + 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = m_run ? pixel_at(m_t) : idle_pix();
    if (!m_run) for (int i = 0; i <= LAT + 1; i++) hist[i] = idle_pix();
  endtask

  // Pixel memory: answers the request made LAT clocks ago, junk otherwise.
  task automatic drive_rgb();
    if (hist[LAT].valid) rgb_in = pix_data(hist[LAT].x, hist[LAT].y);
    else rgb_in = 24'($urandom);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else model_tick();
  end

  always @(negedge clk) drive_rgb();

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic check_output(input string tag);
    pix_t        d;
    logic [25:0] obs_req, exp_req;
    logic [26:0] obs_disp, exp_disp;
    obs_req  = {req_valid, req_x, req_y, frame_start};
    exp_req  = {hist[0].valid, hist[0].x, hist[0].y, hist[0].fs};
    check_eq({tag, "/req"}, 64'(obs_req), 64'(exp_req));
    d        = hist[LAT+1];
    obs_disp = {de, hsync, vsync, rgb_out};
    exp_disp = {d.valid, d.hs, d.vs, (d.valid ? pix_data(d.x, d.y) : 24'h0)};
    check_eq({tag, "/disp"}, 64'(obs_disp), 64'(exp_disp));
  endtask

  task automatic step(input string tag);
    @(negedge clk);
    check_output(tag);
  endtask

  task automatic apply_stimulus(input logic lock, input int cycles, input string tag);
    pll_locked = lock;
    for (int i = 0; i < cycles; i++) step(tag);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n, period, de_cnt, hs_cnt, vs_cnt, first_hs, first_vs;
    data_key   = 24'($urandom);
    rst_n      = 1'b0;
    pll_locked = 1'b0;
    apply_stimulus(1'b0, 3, "reset");
    rst_n = 1'b1;
    apply_stimulus(1'b0, 5, "wait_lock");

    pll_locked = 1'b1;
    n = 0;
    while (!req_valid && n < 20) begin step("cold"); n++; end
    check_eq("cold_req_latency", 64'(n), 64'(3));
    check_eq("cold_origin", 64'({req_x, req_y, frame_start}), 64'({24'h0, 1'b1}));
    n = 0;
    while (!de && n < 20) begin step("cold_de"); n++; end
    check_eq("cold_de_latency", 64'(n), 64'(LAT + 1));

    n = 0;
    while (!frame_start && n < 2 * FRAME) begin step("seek"); n++; end
    check_eq("seek_frame_start", 64'(frame_start), 64'(1));
    period = 0; de_cnt = 0; hs_cnt = 0; vs_cnt = 0; first_hs = -1; first_vs = -1;
    do begin
      step("frame");
      period++;
      if (de) de_cnt++;
      if (hsync == HP) begin
        hs_cnt++;
        if (first_hs < 0 && period > LAT + 1) first_hs = period;
      end
      if (vsync == VP) begin
        vs_cnt++;
        if (first_vs < 0 && period > LAT + 1) first_vs = period;
      end
    end while (!frame_start && period < 2 * FRAME);
    check_eq("frame_period", 64'(period), 64'(FRAME));
    check_eq("frame_de_count", 64'(de_cnt), 64'(HA * VA));
    check_eq("frame_hsync_count", 64'(hs_cnt), 64'(HSW * VT));
    check_eq("frame_vsync_count", 64'(vs_cnt), 64'(VSW * HT));
    check_eq("hsync_start", 64'(first_hs), 64'(HA + HFP + LAT + 1));
    check_eq("vsync_start", 64'(first_vs), 64'((VA + VFP) * HT + LAT + 1));

    for (int k = 0; k < 4; k++) begin
      apply_stimulus(1'b1, int'($urandom_range(150, 20)), "run");
      apply_stimulus(1'b0, 3, "drop");
      check_eq("drop_quiet", 64'({req_valid, de, hsync, vsync, rgb_out}),
               64'({1'b0, 1'b0, ~HP, ~VP, 24'h0}));
      apply_stimulus(1'b0, int'($urandom_range(15, 2)), "unlocked");
      pll_locked = 1'b1;
      n = 0;
      while (!frame_start && n < 10) begin step("relock"); n++; end
      check_eq("relock_latency", 64'(n), 64'(3));
      check_eq("relock_origin", 64'({req_valid, req_x, req_y}), 64'({1'b1, 24'h0}));
    end

    n = 0;
    while (!de && n < 2 * FRAME) begin step("seek_de"); n++; end
    check_eq("seek_de", 64'(de), 64'(1));
    #2 rst_n = 1'b0;
    #1 check_output("async_reset");
    check_eq("async_reset_pins", 64'({req_valid, de, hsync, vsync, rgb_out, frame_start}),
             64'({1'b0, 1'b0, ~HP, ~VP, 24'h0, 1'b0}));
    apply_stimulus(1'b1, 3, "in_reset");
    rst_n = 1'b1;
    n = 0;
    while (!req_valid && n < 20) begin step("restart"); n++; end
    check_eq("restart_req_latency", 64'(n), 64'(3));
    apply_stimulus(1'b1, 2 * FRAME, "tail");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, default 1600, visible pixels per line.
REQ-002 Parameter H_FP / H_SYNC / H_BP, defaults 64 / 192 / 304, horizontal porches and sync width in pixel clocks; line total 2160.
REQ-003 Parameter V_ACTIVE, default 1200, visible lines per frame.
REQ-004 Parameter V_FP / V_SYNC / V_BP, defaults 1 / 3 / 46, vertical porches and sync in lines; frame total 1250.
REQ-005 Parameter HS_POL / VS_POL, default 1 / 1, active level of hsync / vsync.
REQ-006 Parameter RD_LAT, default 2, range 1..8, fixed latency in clocks from req_valid to rgb_in.
REQ-007 clk  in  1  pixel clock, 162 MHz from the pixel PLL.
REQ-008 rst_n  in  1  asynchronous active-low reset.
REQ-009 pll_locked  in  1  PLL lock flag, asynchronous to clk.
REQ-010 req_valid  out  1  pixel request; high for every active pixel.
REQ-011 req_x / req_y  out  12 / 12  coordinate of the requested pixel.
REQ-012 rgb_in  in  24  pixel data, returned exactly RD_LAT clocks after its request.
REQ-013 hsync / vsync / de  out  1 each  display timing, aligned with rgb_out.
REQ-014 rgb_out  out  24  pixel to the DAC or encoder; 0 whenever de=0.
REQ-015 frame_start  out  1  one-clock pulse on the request side at h=0, v=0.

Function
REQ-016 The block SHALL synchronise pll_locked with a 2-flop synchroniser into lock_s.
REQ-017 The FSM SHALL have two states, WAIT_LOCK and RUN; reset enters WAIT_LOCK.
REQ-018 In WAIT_LOCK, the h/v counters SHALL be held at 0 and req_valid SHALL be 0; lock_s=1 moves the FSM to RUN on the next clock.
REQ-019 In RUN, the 12-bit h counter SHALL increment every clock and wrap from H_TOTAL-1 to 0.
REQ-020 The v counter SHALL increment on h wrap and wrap from V_TOTAL-1 to 0, advancing together with the h wrap.
REQ-021 The first RUN cycle SHALL be h=0, v=0, so every frame starts at pixel (0,0).
REQ-022 req_valid SHALL equal (h<H_ACTIVE && v<V_ACTIVE), with req_x=h and req_y=v; req_x/req_y are 0 when req_valid=0.
REQ-023 The raw sync terms SHALL be: hsync active for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC; vsync active for V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, on whole lines with h not considered.
REQ-024 de, hsync and vsync SHALL be delayed by an RD_LAT+1 stage shift register.
REQ-025 rgb_out SHALL register rgb_in when the delayed de=1, and be 0 otherwise; total request-to-output latency is RD_LAT+1.
REQ-026 frame_start SHALL be high for exactly one clock each time the FSM is in RUN with h=0, v=0.
REQ-027 lock_s falling while in RUN SHALL return the FSM to WAIT_LOCK on the next clock. Counters clear, and the delay pipeline is flushed synchronously: de=0, syncs inactive, rgb_out=0.
REQ-028 If lock is regained, timing SHALL restart at (0,0) with no partial frame.
REQ-029 All outputs SHALL be registered.

Reset
REQ-030 While rst_n=0, and asynchronously:
- FSM is WAIT_LOCK; counters, synchroniser and shift register are 0.
- req_valid=0, req_x=req_y=0, de=0, rgb_out=0, frame_start=0.
- hsync=~HS_POL, vsync=~VS_POL.
REQ-031 Deassertion of rst_n mid-frame SHALL behave identically to a cold start.

Structure
REQ-032 A shared package vga_pkg SHALL hold the default timing constants, the derived H_TOTAL/V_TOTAL values, the counter width (12) and the FSM state enum.
REQ-033 The lock synchroniser SHALL be a sub-module sync_2ff, reusable by other clock-domain crossings.

Verification
REQ-034 Cold start: rst_n low, then pll_locked=1 at t0 -> first req_valid at t0+3 clocks with (0,0); first de=1 RD_LAT+1 clocks later.
REQ-035 Defaults, one full frame:
- exactly 2160*1250 clocks between frame_start pulses;
- 1600*1200 de cycles;
- hsync high 192 clocks starting at h=1664;
- vsync high for lines 1201-1203.
REQ-036 Small parameters (H 8/2/2/2, V 4/1/1/1, RD_LAT=3), model returns rgb_in={y,x} -> rgb_out equals {y,x} for each de pixel, and 0 during blanking.
REQ-037 Drop pll_locked at h=500, v=600 -> within 3 clocks req_valid=0 and de=0, syncs inactive, rgb_out=0. Re-lock -> restart at (0,0) with frame_start.
REQ-038 Assert rst_n low mid-line with de=1 -> all outputs reach reset values immediately, without a clock edge.
